seg_display_ctrl: RTL and testbench

Parametrised, clocked seven-segment display controller for the CPU board, the successor to the two-digit unclocked formatter. It latches an N-digit hex value on a load strobe and decodes every digit into registered segment patterns. It adds leading-zero suppression, per-digit blinking and a time-multiplexed scan output for shared-segment displays. It sits between the CPU output register and the board HEX pins.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/seven_seg_dec.sv | 10 +
 rtl/seg_display_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_display_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller: blank pattern,
// hex decode table (active-low, bit order g..a) and counter width helper.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n is the active-low g..a pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h04, 7'h21, 7'h46,   // F E D C
    7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Bits needed for a counter running 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_dec.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_dec (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  import seg_pkg::*;

  assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/seg_display_ctrl.sv
// N-digit seven-segment controller: latches a hex value on load, decodes
// every digit into registered parallel segments with leading-zero
// suppression and per-digit blink, and scans one digit at a time onto a
// shared segment bus.
module seg_display_ctrl #(
  parameter int NDIGITS   = 6,
  parameter int BLINK_DIV = 25_000_000,
  parameter int SCAN_DIV  = 50_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [4*NDIGITS-1:0]   i_data_in,
  input  logic                   i_load,
  input  logic                   i_blank_lz,
  input  logic [NDIGITS-1:0]     i_blink_en,
  output logic [7*NDIGITS-1:0]   o_hex,
  output logic [6:0]             o_seg,
  output logic [NDIGITS-1:0]     o_an,
  output logic [3:0]             o_upd_cnt
);
  import seg_pkg::*;

  localparam int BW = cnt_w(BLINK_DIV);
  localparam int SW = cnt_w(SCAN_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [BW-1:0]      BLINK_TC = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0]      SCAN_TC  = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]      IDX_LAST = IW'(NDIGITS - 1);
  localparam logic [NDIGITS-1:0] AN_ONE   = NDIGITS'(1);

  logic [4*NDIGITS-1:0]        r_data_q;
  logic [3:0]                  r_upd_cnt;
  logic [BW-1:0]               r_bpre;
  logic                        r_blink_ph;
  logic [SW-1:0]               r_spre;
  logic [IW-1:0]               r_idx;
  logic [NDIGITS-1:0][6:0]     r_hex;
  logic [6:0]                  r_seg;
  logic [NDIGITS-1:0]          r_an;

  logic                        w_bpre_tc;
  logic                        w_blink_ph_nxt;
  logic                        w_spre_tc;
  logic [NDIGITS-1:0][6:0]     w_dec;
  logic [NDIGITS-1:0]          w_zero;
  logic [NDIGITS-1:0]          w_lz;
  logic [NDIGITS-1:0][6:0]     w_hex_nxt;

  assign w_bpre_tc = (r_bpre == BLINK_TC);
  assign w_spre_tc = (r_spre == SCAN_TC);
  // Blanking uses the phase being entered this edge so hex tracks blink_ph.
  assign w_blink_ph_nxt = r_blink_ph ^ w_bpre_tc;

  // Input latch and accepted-load counter; rst wins over a coincident load.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_q  <= '0;
      r_upd_cnt <= '0;
    end else if (i_load) begin
      r_data_q  <= i_data_in;
      r_upd_cnt <= r_upd_cnt + 4'd1;
    end
  end

  // Blink prescaler; phase flips on terminal count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bpre     <= '0;
      r_blink_ph <= 1'b0;
    end else begin
      r_bpre     <= w_bpre_tc ? '0 : r_bpre + 1'b1;
      r_blink_ph <= w_blink_ph_nxt;
    end
  end

  // Scan prescaler and digit index; index wraps after the top digit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_spre <= '0;
      r_idx  <= '0;
    end else begin
      r_spre <= w_spre_tc ? '0 : r_spre + 1'b1;
      if (w_spre_tc)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // Per-digit decoders and zero detect.
  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    seven_seg_dec u_dec (
      .i_nib (r_data_q[4*g +: 4]),
      .o_seg (w_dec[g])
    );
    assign w_zero[g] = (r_data_q[4*g +: 4] == 4'd0);
  end

  // Leading-zero chain from the MSB down; digit 0 is never a leading zero.
  always_comb begin
    logic run;
    w_lz = '0;
    run  = 1'b1;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      run     = run & w_zero[i];
      w_lz[i] = run;
    end
  end

  // Next parallel pattern: blink blanking overrides everything else.
  always_comb begin
    w_hex_nxt = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (i_blink_en[i] && w_blink_ph_nxt)
        w_hex_nxt[i] = SEG_BLANK;
      else if (i_blank_lz && w_lz[i])
        w_hex_nxt[i] = SEG_BLANK;
      else
        w_hex_nxt[i] = w_dec[i];
    end
  end

  // Output registers; seg and an both come from idx so they switch together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hex <= {NDIGITS{SEG_BLANK}};
      r_seg <= SEG_BLANK;
      r_an  <= '1;
    end else begin
      r_hex <= w_hex_nxt;
      r_seg <= r_hex[r_idx];
      r_an  <= ~(AN_ONE << r_idx);
    end
  end

  assign o_hex     = r_hex;
  assign o_seg     = r_seg;
  assign o_an      = r_an;
  assign o_upd_cnt = r_upd_cnt;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl (6 digits, blink every 4, scan every 3).
// Expectations are queued as stimulus is applied and checked after the edge.
module tb_seg_display_ctrl;

  localparam int ND = 6;
  localparam int K_HEX = 0, K_SEG = 1, K_AN = 2, K_UPD = 3;

  typedef struct {
    string       tag;
    int          kind;
    logic [41:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, load, blank_lz;
  logic [23:0]   data_in;
  logic [5:0]    blink_en;
  logic [41:0]   hex;
  logic [6:0]    seg;
  logic [5:0]    an;
  logic [3:0]    upd_cnt;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  seg_display_ctrl #(.NDIGITS(ND), .BLINK_DIV(4), .SCAN_DIV(3)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_in  (data_in),
    .i_load     (load),
    .i_blank_lz (blank_lz),
    .i_blink_en (blink_en),
    .o_hex      (hex),
    .o_seg      (seg),
    .o_an       (an),
    .o_upd_cnt  (upd_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h04; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [41:0] hex_of(input logic [23:0] d);
    logic [41:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[7*i +: 7] = dec(d[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [41:0] h6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  task automatic push(input int k, input string t, input logic [41:0] v);
    exp_t e;
    e.tag = t; e.kind = k; e.exp = v;
    sb.push_back(e);
  endtask

  // Advance one edge, then drain the scoreboard against the outputs.
  task automatic step();
    exp_t        e;
    logic [41:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_HEX:   obs = hex;
        K_SEG:   obs = 42'(seg);
        K_AN:    obs = 42'(an);
        default: obs = 42'(upd_cnt);
      endcase
      tests++;
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s (cycle %0d): observed %h expected %h", e.tag, cyc, obs, e.exp);
      end
    end
  endtask

  task automatic do_reset(input string t);
    rst = 1'b1;
    push(K_HEX, {t, "_hex"}, {6{7'h7F}});
    push(K_SEG, {t, "_seg"}, 42'h7F);
    push(K_AN,  {t, "_an"},  42'h3F);
    push(K_UPD, {t, "_upd"}, 42'd0);
    step();
    cyc = 0;
    rst = 1'b0;
  endtask

  logic [41:0] ALL40, H1, last_hex;
  logic [23:0] last_d;

  initial begin
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0; blink_en = '0; data_in = '0;
    ALL40 = h6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40);
    H1    = h6(7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E);

    // Reset state, then data_q=0 visible as all zeros.
    do_reset("rst");
    push(K_HEX, "hex_after_rst", ALL40);
    step();

    // Basic decode and load latency.
    data_in = 24'h12AB0F; load = 1'b1;
    push(K_UPD, "upd_first_load", 42'd1);
    step();
    load = 1'b0; data_in = 24'hFFFFFF;
    push(K_HEX, "dec_12AB0F", H1);
    step();
    push(K_HEX, "no_load_hold", H1);
    push(K_UPD, "no_load_upd", 42'd1);
    step();

    // Scan: seg/an at edge n reflect idx and hex after edge n-1.
    for (int k = 0; k < 18; k++) begin
      int n, ix;
      logic [5:0] a;
      n  = cyc + 1;
      ix = ((n - 1) / 3) % ND;
      a  = ~(6'd1 << ix);
      push(K_SEG, "scan_seg", 42'(H1[7*ix +: 7]));
      push(K_AN,  "scan_an",  42'(a));
      step();
    end

    // Leading-zero suppression.
    blank_lz = 1'b1; data_in = 24'h000305; load = 1'b1;
    push(K_UPD, "upd_lz_load", 42'd2);
    step();
    load = 1'b0;
    push(K_HEX, "lz_000305", h6(7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12));
    step();
    data_in = 24'h0; load = 1'b1;
    step();
    load = 1'b0;
    push(K_HEX, "lz_zero", h6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));
    step();
    blank_lz = 1'b0;
    push(K_HEX, "lz_clear", ALL40);
    step();

    // Blink on digit 0: blanked while blink_ph=1, phase flips every 4th edge.
    do_reset("rst_blink");
    blink_en = 6'b000001; data_in = 24'h000008; load = 1'b1;
    push(K_HEX, "blink_pre_load", ALL40);
    push(K_UPD, "blink_upd", 42'd1);
    step();
    load = 1'b0;
    for (int n = 2; n <= 13; n++) begin
      logic [6:0] d0;
      d0 = ((n / 4) % 2 == 1) ? 7'h7F : 7'h00;
      push(K_HEX, "blink_digit0", h6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, d0));
      step();
    end
    blink_en = 6'b000000;   // edge 14 is in a blank phase
    push(K_HEX, "blink_en_off", h6(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h00));
    step();

    // 17 back-to-back loads: counter wraps to 1, last value shown.
    do_reset("rst_wrap");
    for (int i = 0; i < 17; i++) begin
      data_in = 24'($urandom);
      last_d  = data_in;
      load    = 1'b1;
      push(K_UPD, "b2b_upd", 42'((i + 1) % 16));
      step();
    end
    load = 1'b0;
    last_hex = hex_of(last_d);
    push(K_HEX, "b2b_last_hex", last_hex);
    push(K_UPD, "wrap_upd", 42'd1);
    step();

    // Reset mid-operation with a coincident load.
    blink_en = 6'b111111; data_in = 24'hABCDEF; load = 1'b1;
    repeat (5) step();
    load = 1'b0;
    repeat (2) step();
    load = 1'b1; data_in = 24'h123456;
    do_reset("rst_mid");
    load = 1'b0;
    push(K_HEX, "rst_mid_dataq", ALL40);
    push(K_UPD, "rst_mid_noload", 42'd0);
    push(K_AN,  "rst_mid_an1", 42'h3E);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
